fibo_checker: RTL and testbench



---
 rtl/fibo_pkg.sv | 23 ++
 rtl/fibo_next_calc.sv | 22 ++
 rtl/fibo_checker.sv | 153 +++++++++++++++
 tb/tb_fibo_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// +------------------------------------------------------------------+
// | fibo_pkg : shared types and defaults for the Fibonacci blocks     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package fibo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_SEED0 = 0;
  localparam int DEFAULT_SEED1 = 1;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_S0 = 2'd0,
    WAIT_S1 = 2'd1,
    TRACK   = 2'd2,
    FAIL    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fibo_next_calc.sv
// +------------------------------------------------------------------+
// | fibo_next_calc : WIDTH-bit term adder with carry-out              |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fibo_next_calc
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/fibo_checker.sv
// +------------------------------------------------------------------+
// | fibo_checker : checks a received term stream against Fibonacci    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fibo_checker
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEED0 = DEFAULT_SEED0,
  parameter int SEED1 = DEFAULT_SEED1,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             restart,
  output logic             locked,
  output logic             term_ok,
  output logic             mismatch,
  output logic             error,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] term_count,
  output logic             wrap_seen
);

  localparam logic [WIDTH-1:0] SEED0_V = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] SEED1_V = WIDTH'(SEED1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev0_q, prev0_d;
  logic [WIDTH-1:0] prev1_q, prev1_d;
  logic [CNT_W-1:0] term_count_q, term_count_d;
  logic             term_ok_q, term_ok_d;
  logic             mismatch_q, mismatch_d;
  logic             error_q, error_d;
  logic             wrap_seen_q, wrap_seen_d;

  logic [WIDTH-1:0] sum_w;
  logic             carry_w;

  fibo_next_calc #(.WIDTH(WIDTH)) u_next_calc (
    .a     (prev0_q),
    .b     (prev1_q),
    .sum   (sum_w),
    .carry (carry_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_S0;
      prev0_q      <= '0;
      prev1_q      <= '0;
      term_count_q <= '0;
      term_ok_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      error_q      <= 1'b0;
      wrap_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev0_q      <= prev0_d;
      prev1_q      <= prev1_d;
      term_count_q <= term_count_d;
      term_ok_q    <= term_ok_d;
      mismatch_q   <= mismatch_d;
      error_q      <= error_d;
      wrap_seen_q  <= wrap_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prev0_d      = prev0_q;
    prev1_d      = prev1_q;
    term_count_d = term_count_q;
    term_ok_d    = 1'b0;
    mismatch_d   = 1'b0;
    error_d      = error_q;
    wrap_seen_d  = wrap_seen_q;

    // restart beats a coincident sample, which is dropped
    if (restart) begin
      state_d      = WAIT_S0;
      prev0_d      = '0;
      prev1_d      = '0;
      term_count_d = '0;
      error_d      = 1'b0;
      wrap_seen_d  = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        WAIT_S0: begin
          if (in_data == SEED0_V) begin
            state_d      = WAIT_S1;
            prev1_d      = in_data;
            term_count_d = CNT_W'(1);
          end
        end
        WAIT_S1: begin
          // SEED1 is tested first so equal seeds lock rather than re-seed
          if (in_data == SEED1_V) begin
            state_d      = TRACK;
            prev0_d      = prev1_q;
            prev1_d      = in_data;
            term_count_d = CNT_W'(2);
          end else if (in_data == SEED0_V) begin
            prev1_d      = in_data;
            term_count_d = CNT_W'(1);
          end else begin
            state_d      = WAIT_S0;
            term_count_d = '0;
          end
        end
        TRACK: begin
          if (in_data == sum_w) begin
            prev0_d   = prev1_q;
            prev1_d   = in_data;
            term_ok_d = 1'b1;
            if (term_count_q != CNT_MAX) term_count_d = term_count_q + CNT_W'(1);
            if (carry_w) wrap_seen_d = 1'b1;
          end else begin
            state_d    = FAIL;
            mismatch_d = 1'b1;
            error_d    = 1'b1;
          end
        end
        FAIL: ;
        default: state_d = WAIT_S0;
      endcase
    end
  end

  always_comb begin
    expected = sum_w;
    unique case (state_q)
      WAIT_S0: expected = SEED0_V;
      WAIT_S1: expected = SEED1_V;
      default: expected = sum_w;
    endcase
  end

  assign locked     = (state_q == TRACK);
  assign term_ok    = term_ok_q;
  assign mismatch   = mismatch_q;
  assign error      = error_q;
  assign term_count = term_count_q;
  assign wrap_seen  = wrap_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_fibo_checker.sv
// +------------------------------------------------------------------+
// | tb_fibo_checker : table vectors, corner sequences, random stream  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_fibo_checker;

  localparam int W  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_valid, a_restart, a_locked, a_ok, a_mm, a_err, a_wrap;
  logic [W-1:0]  a_data, a_exp;
  logic [CW-1:0] a_cnt;
  logic          b_valid, b_restart, b_locked, b_ok, b_mm, b_err, b_wrap;
  logic [W-1:0]  b_data, b_exp;
  logic [CW-1:0] b_cnt;

  fibo_checker #(.WIDTH(W), .SEED0(0), .SEED1(1), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .restart(a_restart),
    .locked(a_locked), .term_ok(a_ok), .mismatch(a_mm), .error(a_err),
    .expected(a_exp), .term_count(a_cnt), .wrap_seen(a_wrap)
  );

  // equal seeds exercise the SEED1-first tie-break
  fibo_checker #(.WIDTH(W), .SEED0(1), .SEED1(1), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data), .restart(b_restart),
    .locked(b_locked), .term_ok(b_ok), .mismatch(b_mm), .error(b_err),
    .expected(b_exp), .term_count(b_cnt), .wrap_seen(b_wrap)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int lk, ok, mm, er, ex, cnt, wr);
    chk({tag, "_locked"},   int'(a_locked), lk);
    chk({tag, "_term_ok"},  int'(a_ok),     ok);
    chk({tag, "_mismatch"}, int'(a_mm),     mm);
    chk({tag, "_error"},    int'(a_err),    er);
    chk({tag, "_expected"}, int'(a_exp),    ex);
    chk({tag, "_count"},    int'(a_cnt),    cnt);
    chk({tag, "_wrap"},     int'(a_wrap),   wr);
  endtask

  task automatic chk_b(input string tag, input int lk, ok, mm, er, ex, cnt);
    chk({tag, "_locked"},   int'(b_locked), lk);
    chk({tag, "_term_ok"},  int'(b_ok),     ok);
    chk({tag, "_mismatch"}, int'(b_mm),     mm);
    chk({tag, "_error"},    int'(b_err),    er);
    chk({tag, "_expected"}, int'(b_exp),    ex);
    chk({tag, "_count"},    int'(b_cnt),    cnt);
  endtask

  task automatic drive_a(input bit rst, input bit v, input int d, input bit rs);
    @(negedge clk);
    reset = rst; a_valid = v; a_data = W'(d); a_restart = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input bit v, input int d, input bit rs);
    @(negedge clk);
    b_valid = v; b_data = W'(d); b_restart = rs;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst; bit v; int d; bit rs;
    int lk; int ok; int mm; int er; int ex; int cnt; int wr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit v, int d, bit rs,
                              int lk, int ok, int mm, int er, int ex, int cnt, int wr);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rs = rs;
    t.lk = lk; t.ok = ok; t.mm = mm; t.er = er; t.ex = ex; t.cnt = cnt; t.wr = wr;
    tbl.push_back(t);
  endfunction

  // Reference model: the list of accepted terms defines everything else.
  localparam int MOD = 1 << W;
  int unsigned hist[$];
  bit m_failed, m_wrap, m_ok, m_mm;

  function automatic int m_expected();
    if (hist.size() == 0) return 0;
    if (hist.size() == 1) return 1;
    return int'((hist[hist.size()-1] + hist[hist.size()-2]) % MOD);
  endfunction

  function automatic void m_clear();
    hist.delete(); m_failed = 0; m_wrap = 0; m_ok = 0; m_mm = 0;
  endfunction

  function automatic void m_step(bit v, int d, bit rs);
    int unsigned s;
    m_ok = 0; m_mm = 0;
    if (rs) begin
      m_clear();
    end else if (v && !m_failed) begin
      if (hist.size() == 0) begin
        if (d == 0) hist.push_back(d);
      end else if (hist.size() == 1) begin
        if (d == 1) hist.push_back(d);
        else if (d == 0) begin hist.delete(); hist.push_back(d); end
        else hist.delete();
      end else begin
        s = hist[hist.size()-1] + hist[hist.size()-2];
        if (d == int'(s % MOD)) begin
          hist.push_back(d); m_ok = 1;
          if (s >= MOD) m_wrap = 1;
        end else begin
          m_failed = 1; m_mm = 1;
        end
      end
    end
  endfunction

  initial begin
    reset = 1; a_valid = 0; a_data = 0; a_restart = 0;
    b_valid = 0; b_data = 0; b_restart = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("rst_a", 0, 0, 0, 0, 0, 0, 0);
    chk_b("rst_b", 0, 0, 0, 0, 1, 0);

    // lock and run through the mod-16 wrap
    add(0,1, 0,0, 0,0,0,0, 1, 1,0);
    add(0,1, 1,0, 1,0,0,0, 1, 2,0);
    add(0,1, 1,0, 1,1,0,0, 2, 3,0);
    add(0,1, 2,0, 1,1,0,0, 3, 4,0);
    add(0,1, 3,0, 1,1,0,0, 5, 5,0);
    add(0,1, 5,0, 1,1,0,0, 8, 6,0);
    add(0,1, 8,0, 1,1,0,0,13, 7,0);
    add(0,1,13,0, 1,1,0,0, 5, 8,0);
    add(0,1, 5,0, 1,1,0,0, 2, 9,1);
    add(0,1, 2,0, 1,1,0,0, 7,10,1);
    add(0,1, 7,0, 1,1,0,0, 9,11,1);
    add(0,1, 9,0, 1,1,0,0, 0,12,1);
    add(0,1, 0,0, 1,1,0,0, 9,13,1);
    add(0,1, 9,0, 1,1,0,0, 9,14,1);
    add(0,1, 9,0, 1,1,0,0, 2,15,1);
    add(0,1, 2,0, 1,1,0,0,11,16,1);
    add(0,0,11,0, 1,0,0,0,11,16,1);
    add(0,1, 4,0, 0,0,1,1,11,16,1);
    add(0,1,11,0, 0,0,0,1,11,16,1);
    add(0,1, 0,1, 0,0,0,0, 0, 0,0);
    // mismatch on a short stream, then restart without a sample
    add(0,1, 0,0, 0,0,0,0, 1, 1,0);
    add(0,1, 1,0, 1,0,0,0, 1, 2,0);
    add(0,1, 1,0, 1,1,0,0, 2, 3,0);
    add(0,1, 2,0, 1,1,0,0, 3, 4,0);
    add(0,1, 4,0, 0,0,1,1, 3, 4,0);
    add(0,1, 3,0, 0,0,0,1, 3, 4,0);
    add(0,0, 0,1, 0,0,0,0, 0, 0,0);
    // hunting and re-seeding
    add(0,1, 7,0, 0,0,0,0, 0, 0,0);
    add(0,1, 0,0, 0,0,0,0, 1, 1,0);
    add(0,1, 0,0, 0,0,0,0, 1, 1,0);
    add(0,1, 1,0, 1,0,0,0, 1, 2,0);
    add(0,1, 1,0, 1,1,0,0, 2, 3,0);
    add(0,1, 2,0, 1,1,0,0, 3, 4,0);
    // restart with a matching sample in TRACK
    add(0,1, 3,1, 0,0,0,0, 0, 0,0);
    add(0,0, 3,0, 0,0,0,0, 0, 0,0);
    // gapped stream
    add(0,1, 0,0, 0,0,0,0, 1, 1,0);
    add(0,0, 0,0, 0,0,0,0, 1, 1,0);
    add(0,1, 1,0, 1,0,0,0, 1, 2,0);
    add(0,0, 1,0, 1,0,0,0, 1, 2,0);
    add(0,0, 2,0, 1,0,0,0, 1, 2,0);
    add(0,1, 1,0, 1,1,0,0, 2, 3,0);
    add(0,1, 2,0, 1,1,0,0, 3, 4,0);
    // mid-stream reset, mid-sequence term, bad second seed
    add(1,1, 3,0, 0,0,0,0, 0, 0,0);
    add(0,1, 5,0, 0,0,0,0, 0, 0,0);
    add(0,1, 0,0, 0,0,0,0, 1, 1,0);
    add(0,1, 6,0, 0,0,0,0, 0, 0,0);

    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rs);
      chk_a($sformatf("vec%0d", i), tbl[i].lk, tbl[i].ok, tbl[i].mm, tbl[i].er,
            tbl[i].ex, tbl[i].cnt, tbl[i].wr);
    end

    // equal seeds: second 1 locks instead of re-seeding
    drive_b(0, 0, 1); chk_b("eq_clr", 0, 0, 0, 0, 1, 0);
    drive_b(1, 1, 0); chk_b("eq_s0",  0, 0, 0, 0, 1, 1);
    drive_b(1, 1, 0); chk_b("eq_s1",  1, 0, 0, 0, 2, 2);
    drive_b(1, 2, 0); chk_b("eq_t2",  1, 1, 0, 0, 3, 3);
    drive_b(1, 4, 0); chk_b("eq_bad", 0, 0, 1, 1, 3, 3);
    drive_b(0, 0, 0);

    // random stream: clean phase saturates the counter, then errors and restarts
    drive_a(0, 0, 0, 1);
    m_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit v, rs;
      int d;
      v  = ($urandom_range(0, 9) < 8);
      rs = (cyc >= 700) && ($urandom_range(0, 149) == 0);
      if (cyc >= 700 && $urandom_range(0, 39) == 0) d = int'($urandom_range(0, MOD-1));
      else d = m_expected();
      drive_a(0, v, d, rs);
      m_step(v, d, rs);
      chk_a($sformatf("rnd%0d", cyc), int'(hist.size() >= 2 && !m_failed), int'(m_ok),
            int'(m_mm), int'(m_failed), m_expected(),
            (hist.size() > 255) ? 255 : hist.size(), int'(m_wrap));
      if (cyc == 699) chk("sat_count", int'(a_cnt), 255);
    end

    a_valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
